// File: rtl/mc_maindec_if.sv
// mc_maindec_if: control/handshake bundle between the multicycle main decoder and the datapath/memory
//   master (decoder): in  op, mem_ready; out mem_req and all datapath control outputs
//   slave  (datapath/memory): the mirror image
interface mc_maindec_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       bne;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [2:0] aluop;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] memwrite;
  logic [2:0] readtype;
  logic       illegal;
  logic       bus_err;
  modport master (
    input  op, mem_ready,
    output mem_req, iord, irwrite, pcwrite, branch, bne, pcsrc, alusrca, alusrcb, zeroext,
           aluop, regwrite, regdst, memtoreg, memwrite, readtype, illegal, bus_err
  );
  modport slave (
    output op, mem_ready,
    input  mem_req, iord, irwrite, pcwrite, branch, bne, pcsrc, alusrca, alusrcb, zeroext,
           aluop, regwrite, regdst, memtoreg, memwrite, readtype, illegal, bus_err
  );
endinterface

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS-64 main decoder FSM with req/ready memory handshake and timeout
//   clk, reset : clock, synchronous active-high reset
//   bus        : mc_maindec_if.master (op, mem_ready in; mem_req and datapath controls out)
//   retired, stall_cyc : performance counters, present only with MC_MAINDEC_PERF_EN defined
module mc_maindec #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic          clk,
  input logic          reset,
  mc_maindec_if.master bus
`ifdef MC_MAINDEC_PERF_EN
  ,
  output logic [31:0]  retired,
  output logic [31:0]  stall_cyc
`endif
);
  localparam logic [5:0] RTYPE = 6'b000000, LD = 6'b110111, LWU = 6'b100111, LW = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100, LB = 6'b100000, SD = 6'b111111, SW = 6'b101011;
  localparam logic [5:0] SB = 6'b101000, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, DADDI = 6'b011000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP
  } state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_ld, is_st, is_imm, mem_st, tmo;
  logic [2:0]       rt, imm_op;
  logic [1:0]       mw;
  assign is_ld  = bus.op inside {LD, LWU, LW, LBU, LB};
  assign is_st  = bus.op inside {SD, SW, SB};
  assign is_imm = bus.op inside {ADDI, DADDI, ANDI, ORI, SLTI};
  assign rt     = bus.op == LWU ? 3'b001 : bus.op == LB ? 3'b010 : bus.op == LBU ? 3'b011 :
                  bus.op == LD ? 3'b100 : 3'b000;
  assign mw     = bus.op == SD ? 2'b11 : bus.op == SW ? 2'b01 : bus.op == SB ? 2'b10 : 2'b00;
  assign imm_op = bus.op == ANDI ? 3'b001 : bus.op == ORI ? 3'b010 : bus.op == SLTI ? 3'b011 : 3'b000;
  // States that hold mem_req high; the wait counter only runs here
  assign mem_st = state_q inside {FETCH, MEMRD, MEMWR};
  // Ready on the limit cycle wins, so timeout requires mem_ready low
  assign tmo    = WAIT_MAX != 0 && mem_st && !bus.mem_ready && cnt_q == CNT_W'(WAIT_MAX);
  // Leaving a mem state always goes through ready or timeout, both of which clear the count,
  // so every mem state is entered with a zero counter
  assign cnt_d  = mem_st && !bus.mem_ready && !tmo ?
                  (cnt_q == CNT_W'(WAIT_MAX) ? cnt_q : cnt_q + CNT_W'(1)) : '0;
  always_comb begin
    state_d      = state_q;
    bus.mem_req  = 1'b0;
    bus.iord     = 1'b0;
    bus.irwrite  = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.bne      = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.zeroext  = 1'b0;
    bus.aluop    = 3'b000;
    bus.regwrite = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.memwrite = 2'b00;
    bus.readtype = 3'b000;
    bus.illegal  = 1'b0;
    bus.bus_err  = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.alusrcb = 2'b01;
          bus.irwrite = bus.mem_ready;
          bus.pcwrite = bus.mem_ready;
          state_d     = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          bus.alusrcb = 2'b11;
          state_d     = is_ld || is_st ? MEMADR : bus.op == RTYPE ? EXEC : is_imm ? IMMEX :
                        bus.op inside {BEQ, BNE} ? BRANCH : bus.op == J ? JUMP : FETCH;
          bus.illegal = state_d == FETCH;
        end
        MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
          state_d     = is_ld ? MEMRD : MEMWR;
        end
        MEMRD: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.readtype = rt;
          state_d      = bus.mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
          bus.readtype = rt;
          state_d      = FETCH;
        end
        MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.memwrite = mw;
          state_d      = bus.mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 3'b111;
          state_d     = ALUWB;
        end
        ALUWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
          state_d      = FETCH;
        end
        IMMEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
          bus.aluop   = imm_op;
          bus.zeroext = bus.op inside {ANDI, ORI};
          state_d     = IMMWB;
        end
        IMMWB: begin
          bus.regwrite = 1'b1;
          state_d      = FETCH;
        end
        BRANCH: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 3'b100;
          bus.branch  = 1'b1;
          bus.bne     = bus.op == BNE;
          bus.pcsrc   = 2'b01;
          state_d     = FETCH;
        end
        JUMP: begin
          bus.pcwrite = 1'b1;
          bus.pcsrc   = 2'b10;
          state_d     = FETCH;
        end
        default: state_d = FETCH;
      endcase
      if (tmo) begin
        bus.bus_err  = 1'b1;
        bus.memwrite = 2'b00;
        state_d      = FETCH;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef MC_MAINDEC_PERF_EN
  logic [31:0] retired_q, stall_q;
  logic        ret;
  assign ret = state_q inside {MEMWB, ALUWB, IMMWB, BRANCH, JUMP} || (state_q == MEMWR && bus.mem_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_q + 32'(ret);
      stall_q   <= stall_q + 32'(mem_st && !bus.mem_ready);
    end
  end
  assign retired   = retired_q;
  assign stall_cyc = stall_q;
`endif
endmodule
